regpair_seq: RTL and testbench

Parametrised byte-addressable register bank with a built-in byte-serial 16-bit pair-operation sequencer (INX, DCX, DAD, XCHG) for the 8085 core datapath. It is the successor to the core's flat register/ALU file. It replaces ad-hoc pair handling with a two-cycle low-byte/high-byte engine that reuses one DATASIZE-wide adder. The control unit issues pair operations through a go/busy/done handshake and keeps normal byte read/write access to every register.

---
 rtl/regpair_seq_pkg.sv | 34 +++
 rtl/regpair_seq_if.sv | 39 +++
 rtl/addc8.sv | 25 ++
 rtl/regpair_seq.sv | 142 ++++++++++++++
 tb/tb_regpair_seq.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regpair_seq_pkg.sv
// regpair_seq_pkg
//   Shared definitions for the register-pair sequencer: pair-operation
//   command encodings, pair and byte register indices, and the sequencer
//   state encoding.
//   Byte index 2p holds the high byte of pair p; 2p+1 holds the low byte.
package regpair_seq_pkg;

  typedef logic [1:0] op_cmd_t;

  localparam op_cmd_t OP_INX  = 2'b00;
  localparam op_cmd_t OP_DCX  = 2'b01;
  localparam op_cmd_t OP_DAD  = 2'b10;
  localparam op_cmd_t OP_XCHG = 2'b11;

  localparam int REGP_BC = 0;
  localparam int REGP_DE = 1;
  localparam int REGP_HL = 2;
  localparam int REGP_SP = 3;

  localparam int REG_B = 0;
  localparam int REG_C = 1;
  localparam int REG_D = 2;
  localparam int REG_E = 3;
  localparam int REG_H = 4;
  localparam int REG_L = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/regpair_seq_if.sv
// regpair_seq_if
//   Bundles the byte read/write port, the pair read port and the
//   go/busy/done pair-operation handshake of the register bank.
//   master : control unit side (drives strobes, selects, commands)
//   slave  : register bank side (drives read data and status)
interface regpair_seq_if
  import regpair_seq_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int PSELBITS = 2,
  parameter int REGSBITS = PSELBITS + 1
);

  logic                  wr_enb;
  logic [REGSBITS-1:0]   wr_sel;
  logic [DATASIZE-1:0]   wr_dat;
  logic [REGSBITS-1:0]   rd_sel;
  logic [DATASIZE-1:0]   rd_dat;
  logic [PSELBITS-1:0]   rp_sel;
  logic [2*DATASIZE-1:0] rp_dat;
  logic                  op_go;
  op_cmd_t               op_cmd;
  logic [PSELBITS-1:0]   op_rp;
  logic                  op_bsy;
  logic                  op_done;
  logic                  cy_out;
  logic                  cy_vld;

  modport master (
    output wr_enb, wr_sel, wr_dat, rd_sel, rp_sel, op_go, op_cmd, op_rp,
    input  rd_dat, rp_dat, op_bsy, op_done, cy_out, cy_vld
  );

  modport slave (
    input  wr_enb, wr_sel, wr_dat, rd_sel, rp_sel, op_go, op_cmd, op_rp,
    output rd_dat, rp_dat, op_bsy, op_done, cy_out, cy_vld
  );

endinterface

// File: rtl/addc8.sv
// addc8
//   DATASIZE-wide adder with optional inversion of operand b and a
//   carry-in. Increment is a+0+1, decrement is a+~0+0 (carry-out is then
//   the inverted borrow), add-with-carry is a+b+cin.
//   Ports: a, b operands; inv_b inverts b; cin carry-in;
//          sum result; cout carry-out.
module addc8
  import regpair_seq_pkg::*;
#(
  parameter int DATASIZE = 8
) (
  input  logic [DATASIZE-1:0] a,
  input  logic [DATASIZE-1:0] b,
  input  logic                inv_b,
  input  logic                cin,
  output logic [DATASIZE-1:0] sum,
  output logic                cout
);

  logic [DATASIZE-1:0] b_eff;

  assign b_eff = inv_b ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{DATASIZE{1'b0}}, cin};

endmodule

// File: rtl/regpair_seq.sv
// regpair_seq
//   Byte-addressable register bank with a byte-serial 16-bit pair
//   sequencer (INX, DCX, DAD, XCHG). A pair operation runs IDLE->LO->HI->
//   DONE: the low byte is processed in LO, the high byte in HI using the
//   carry captured in LO, and DONE raises a one-cycle op_done.
//   Ports: clk core clock; rst_ synchronous active-high reset;
//          bus (slave modport) byte/pair reads, byte writes, op handshake.
module regpair_seq
  import regpair_seq_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int PSELBITS = 2,
  parameter int REGSBITS = PSELBITS + 1
) (
  input  logic          clk,
  input  logic          rst_,
  regpair_seq_if.slave  bus
);

  localparam int NREGS = 2 ** REGSBITS;
  localparam logic [REGSBITS-1:0] IDX_D = REGSBITS'(REG_D);
  localparam logic [REGSBITS-1:0] IDX_E = REGSBITS'(REG_E);
  localparam logic [REGSBITS-1:0] IDX_H = REGSBITS'(REG_H);
  localparam logic [REGSBITS-1:0] IDX_L = REGSBITS'(REG_L);
  localparam logic [PSELBITS-1:0] PAIR_HL = PSELBITS'(REGP_HL);

  logic [DATASIZE-1:0] regs [NREGS];

  seq_state_t          state_q, state_d;
  op_cmd_t             cmd_q;
  logic [PSELBITS-1:0] rp_q;
  logic                carry_q;
  logic                cy_out_q;

  logic                half_lo;
  logic [PSELBITS-1:0] dst_pair;
  logic [REGSBITS-1:0] src_idx, dst_idx;
  logic [DATASIZE-1:0] add_a, add_b, add_sum;
  logic                add_inv, add_cin, add_cout;

  // Byte under work: the low byte while in LO, the high byte otherwise.
  // DAD always writes HL; INX/DCX write back into the operand pair.
  assign half_lo  = (state_q == ST_LO);
  assign dst_pair = (cmd_q == OP_DAD) ? PAIR_HL : rp_q;
  assign src_idx  = REGSBITS'({rp_q, half_lo});
  assign dst_idx  = REGSBITS'({dst_pair, half_lo});

  // Adder operand steering. The low byte starts with carry-in 1 for INX
  // and 0 otherwise; the high byte continues with the captured carry.
  // DCX adds all-ones so the carry acts as an inverted borrow.
  always_comb begin
    add_a   = regs[src_idx];
    add_b   = '0;
    add_inv = (cmd_q == OP_DCX);
    add_cin = half_lo ? (cmd_q == OP_INX) : carry_q;
    if (cmd_q == OP_DAD) begin
      add_a = regs[dst_idx];
      add_b = regs[src_idx];
    end
  end

  addc8 #(.DATASIZE(DATASIZE)) u_addc8 (
    .a     (add_a),
    .b     (add_b),
    .inv_b (add_inv),
    .cin   (add_cin),
    .sum   (add_sum),
    .cout  (add_cout)
  );

  // Next-state logic: only IDLE waits for op_go, the rest step through.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.op_go) state_d = ST_LO;
      ST_LO:   state_d = ST_HI;
      ST_HI:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, latched command, internal carry and the DAD carry flag.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= ST_IDLE;
      cmd_q    <= OP_INX;
      rp_q     <= '0;
      carry_q  <= 1'b0;
      cy_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.op_go) begin
        cmd_q <= bus.op_cmd;
        rp_q  <= bus.op_rp;
      end
      if (state_q == ST_LO) carry_q <= add_cout;
      if (state_q == ST_HI && cmd_q == OP_DAD) cy_out_q <= add_cout;
    end
  end

  // Register storage. External byte writes are accepted whenever the
  // sequencer is not busy (IDLE or DONE); LO/HI own the write port.
  // XCHG swaps E/L in LO and D/H in HI.
  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.wr_enb) regs[bus.wr_sel] <= bus.wr_dat;
        end
        ST_LO: begin
          if (cmd_q == OP_XCHG) begin
            regs[IDX_L] <= regs[IDX_E];
            regs[IDX_E] <= regs[IDX_L];
          end else begin
            regs[dst_idx] <= add_sum;
          end
        end
        ST_HI: begin
          if (cmd_q == OP_XCHG) begin
            regs[IDX_H] <= regs[IDX_D];
            regs[IDX_D] <= regs[IDX_H];
          end else begin
            regs[dst_idx] <= add_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_dat  = regs[bus.rd_sel];
  assign bus.rp_dat  = {regs[REGSBITS'({bus.rp_sel, 1'b0})],
                        regs[REGSBITS'({bus.rp_sel, 1'b1})]};
  assign bus.op_bsy  = (state_q == ST_LO) || (state_q == ST_HI);
  assign bus.op_done = (state_q == ST_DONE);
  assign bus.cy_vld  = (state_q == ST_DONE) && (cmd_q == OP_DAD);
  assign bus.cy_out  = cy_out_q;

endmodule

// File: tb/tb_regpair_seq.sv
// tb_regpair_seq
//   Self-checking bench for regpair_seq: reset state, a table of pair
//   operations with fixed expected results, hand-written multi-cycle
//   corner sequences, and a randomized run against a 16-bit pair model.
module tb_regpair_seq;
  import regpair_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_ = 1'b0;

  regpair_seq_if #(.DATASIZE(8), .PSELBITS(2), .REGSBITS(3)) bus_if ();

  regpair_seq #(.DATASIZE(8), .PSELBITS(2), .REGSBITS(3)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain byte array plus the DAD carry flag.
  logic [7:0] m [8];
  logic       m_cy;

  typedef struct {
    logic [1:0]  cmd;
    int          rp;
    int          pa;
    logic [15:0] va;
    int          pb;
    logic [15:0] vb;
    int          ca;
    logic [15:0] ea;
    int          cb;
    logic [15:0] eb;
    logic        ecy;
    logic        evld;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [15:0] mpair(input int p);
    return {m[2*p], m[2*p+1]};
  endfunction

  function automatic void mset(input int p, input logic [15:0] v);
    m[2*p]   = v[15:8];
    m[2*p+1] = v[7:0];
  endfunction

  // Pair operations at the 16-bit level, independent of byte sequencing.
  function automatic void model_op(input logic [1:0] cmd, input int rp);
    logic [16:0] s;
    logic [15:0] t;
    case (cmd)
      OP_INX: mset(rp, mpair(rp) + 16'd1);
      OP_DCX: mset(rp, mpair(rp) - 16'd1);
      OP_DAD: begin
        s = {1'b0, mpair(REGP_HL)} + {1'b0, mpair(rp)};
        mset(REGP_HL, s[15:0]);
        m_cy = s[16];
      end
      default: begin
        t = mpair(REGP_DE);
        mset(REGP_DE, mpair(REGP_HL));
        mset(REGP_HL, t);
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.wr_enb = 1'b0;
    bus_if.wr_sel = '0;
    bus_if.wr_dat = '0;
    bus_if.rd_sel = '0;
    bus_if.rp_sel = '0;
    bus_if.op_go  = 1'b0;
    bus_if.op_cmd = OP_INX;
    bus_if.op_rp  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ = 1'b1;
    tick();
    tick();
    rst_ = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    m_cy = 1'b0;
  endtask

  task automatic read_pair(input int p, output logic [15:0] v);
    bus_if.rp_sel = 2'(p);
    #1;
    v = bus_if.rp_dat;
  endtask

  // Byte write with read-after-write check on the following cycle.
  task automatic apply_stimulus(input int sel, input logic [7:0] dat);
    bus_if.wr_enb = 1'b1;
    bus_if.wr_sel = 3'(sel);
    bus_if.wr_dat = dat;
    bus_if.rd_sel = 3'(sel);
    tick();
    bus_if.wr_enb = 1'b0;
    m[sel] = dat;
    check("raw_read", {24'h0, bus_if.rd_dat}, {24'h0, dat});
  endtask

  task automatic load_pair(input int p, input logic [15:0] v);
    apply_stimulus(2*p, v[15:8]);
    apply_stimulus(2*p+1, v[7:0]);
  endtask

  // Issue one operation; returns cy_vld as seen during the op_done cycle.
  task automatic run_op(input logic [1:0] cmd, input int rp, output logic vld);
    int lat;
    bus_if.op_go  = 1'b1;
    bus_if.op_cmd = cmd;
    bus_if.op_rp  = 2'(rp);
    tick();
    bus_if.op_go  = 1'b0;
    bus_if.op_cmd = 2'($urandom_range(0, 3));
    bus_if.op_rp  = 2'($urandom_range(0, 3));
    lat = 0;
    while (bus_if.op_done !== 1'b1 && lat < 8) begin
      check("op_bsy_run", {31'h0, bus_if.op_bsy}, 32'd1);
      tick();
      lat++;
    end
    check("done_latency", lat, 2);
    check("op_bsy_done", {31'h0, bus_if.op_bsy}, 32'd0);
    vld = bus_if.cy_vld;
    model_op(cmd, rp);
    tick();
    check("done_pulse", {31'h0, bus_if.op_done}, 32'd0);
  endtask

  task automatic check_output(input string tag);
    logic [15:0] v;
    for (int p = 0; p < 4; p++) begin
      read_pair(p, v);
      check(tag, {16'h0, v}, {16'h0, mpair(p)});
    end
    check({tag, "_cy"}, {31'h0, bus_if.cy_out}, {31'h0, m_cy});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        vld;
    logic [15:0] v;
    int          cnt;

    vecs[0]  = '{OP_INX,  REGP_BC, REGP_BC, 16'h12FF, REGP_BC, 16'h12FF, REGP_BC, 16'h1300, REGP_BC, 16'h1300, 1'b0, 1'b0};
    vecs[1]  = '{OP_DCX,  REGP_DE, REGP_DE, 16'h0000, REGP_HL, 16'h5A5A, REGP_DE, 16'hFFFF, REGP_HL, 16'h5A5A, 1'b0, 1'b0};
    vecs[2]  = '{OP_DAD,  REGP_BC, REGP_HL, 16'hFFFF, REGP_BC, 16'h0001, REGP_HL, 16'h0000, REGP_BC, 16'h0001, 1'b1, 1'b1};
    vecs[3]  = '{OP_DAD,  REGP_HL, REGP_HL, 16'h1234, REGP_HL, 16'h1234, REGP_HL, 16'h2468, REGP_HL, 16'h2468, 1'b0, 1'b1};
    vecs[4]  = '{OP_DAD,  REGP_DE, REGP_HL, 16'h8000, REGP_DE, 16'h8001, REGP_HL, 16'h0001, REGP_DE, 16'h8001, 1'b1, 1'b1};
    vecs[5]  = '{OP_INX,  REGP_HL, REGP_HL, 16'h00FF, REGP_HL, 16'h00FF, REGP_HL, 16'h0100, REGP_HL, 16'h0100, 1'b1, 1'b0};
    vecs[6]  = '{OP_DCX,  REGP_SP, REGP_SP, 16'h0000, REGP_SP, 16'h0000, REGP_SP, 16'hFFFF, REGP_SP, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{OP_XCHG, REGP_BC, REGP_DE, 16'hABCD, REGP_HL, 16'h1234, REGP_DE, 16'h1234, REGP_HL, 16'hABCD, 1'b1, 1'b0};
    vecs[8]  = '{OP_INX,  REGP_SP, REGP_SP, 16'hFFFF, REGP_SP, 16'hFFFF, REGP_SP, 16'h0000, REGP_SP, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{OP_DCX,  REGP_BC, REGP_BC, 16'h1300, REGP_BC, 16'h1300, REGP_BC, 16'h12FF, REGP_BC, 16'h12FF, 1'b1, 1'b0};
    vecs[10] = '{OP_DAD,  REGP_SP, REGP_HL, 16'h0F0F, REGP_SP, 16'hF0F1, REGP_HL, 16'h0000, REGP_SP, 16'hF0F1, 1'b1, 1'b1};
    vecs[11] = '{OP_DAD,  REGP_BC, REGP_HL, 16'h00FF, REGP_BC, 16'h0001, REGP_HL, 16'h0100, REGP_BC, 16'h0001, 1'b0, 1'b1};

    // Reset state.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus_if.rd_sel = 3'(i);
      #1;
      check("reset_byte", {24'h0, bus_if.rd_dat}, 32'h0);
    end
    check("reset_bsy",  {31'h0, bus_if.op_bsy},  32'd0);
    check("reset_done", {31'h0, bus_if.op_done}, 32'd0);
    check("reset_cy",   {31'h0, bus_if.cy_out},  32'd0);
    check("reset_vld",  {31'h0, bus_if.cy_vld},  32'd0);

    // Table of operations with fixed expected results.
    for (int k = 0; k < 12; k++) begin
      load_pair(vecs[k].pa, vecs[k].va);
      load_pair(vecs[k].pb, vecs[k].vb);
      run_op(vecs[k].cmd, vecs[k].rp, vld);
      read_pair(vecs[k].ca, v);
      check($sformatf("vec%0d_a", k), {16'h0, v}, {16'h0, vecs[k].ea});
      read_pair(vecs[k].cb, v);
      check($sformatf("vec%0d_b", k), {16'h0, v}, {16'h0, vecs[k].eb});
      check($sformatf("vec%0d_cy", k), {31'h0, bus_if.cy_out}, {31'h0, vecs[k].ecy});
      check($sformatf("vec%0d_vld", k), {31'h0, vld}, {31'h0, vecs[k].evld});
    end

    // Half-updated pair is visible between the low and high byte writes.
    load_pair(REGP_BC, 16'h12FF);
    bus_if.rp_sel = 2'(REGP_BC);
    bus_if.op_go  = 1'b1;
    bus_if.op_cmd = OP_INX;
    bus_if.op_rp  = 2'(REGP_BC);
    tick();
    bus_if.op_go = 1'b0;
    check("half_lo", {16'h0, bus_if.rp_dat}, 32'h12FF);
    tick();
    check("half_hi", {16'h0, bus_if.rp_dat}, 32'h1200);
    tick();
    check("half_done", {16'h0, bus_if.rp_dat}, 32'h1300);
    check("half_done_pulse", {31'h0, bus_if.op_done}, 32'd1);
    tick();

    // XCHG with a byte write to D attempted while busy.
    load_pair(REGP_DE, 16'hABCD);
    load_pair(REGP_HL, 16'h1234);
    bus_if.op_go  = 1'b1;
    bus_if.op_cmd = OP_XCHG;
    tick();
    bus_if.op_go  = 1'b0;
    bus_if.wr_enb = 1'b1;
    bus_if.wr_sel = 3'(REG_D);
    bus_if.wr_dat = 8'h77;
    tick();
    tick();
    bus_if.wr_enb = 1'b0;
    check("xchg_done", {31'h0, bus_if.op_done}, 32'd1);
    bus_if.rd_sel = 3'(REG_D);
    #1;
    check("xchg_d_kept", {24'h0, bus_if.rd_dat}, 32'h12);
    read_pair(REGP_HL, v);
    check("xchg_hl", {16'h0, v}, 32'hABCD);
    tick();

    // op_go held through busy: exactly one operation.
    load_pair(REGP_BC, 16'h0005);
    cnt = 0;
    bus_if.op_go  = 1'b1;
    bus_if.op_cmd = OP_INX;
    bus_if.op_rp  = 2'(REGP_BC);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus_if.op_done) cnt++;
    end
    bus_if.op_go = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_if.op_done) cnt++;
    end
    check("go_busy_done_count", cnt, 1);
    read_pair(REGP_BC, v);
    check("go_busy_bc", {16'h0, v}, 32'h0006);

    // Byte write and op_go in the same idle cycle.
    load_pair(REGP_BC, 16'h12AA);
    bus_if.wr_enb = 1'b1;
    bus_if.wr_sel = 3'(REG_C);
    bus_if.wr_dat = 8'hFF;
    bus_if.op_go  = 1'b1;
    bus_if.op_cmd = OP_INX;
    bus_if.op_rp  = 2'(REGP_BC);
    tick();
    bus_if.wr_enb = 1'b0;
    bus_if.op_go  = 1'b0;
    tick();
    tick();
    check("go_wr_done", {31'h0, bus_if.op_done}, 32'd1);
    read_pair(REGP_BC, v);
    check("go_wr_bc", {16'h0, v}, 32'h1300);
    tick();

    // Reset at the low-byte edge of an INX after a carry-setting DAD.
    load_pair(REGP_HL, 16'hFFFF);
    load_pair(REGP_BC, 16'h0001);
    run_op(OP_DAD, REGP_BC, vld);
    check("pre_rst_cy", {31'h0, bus_if.cy_out}, 32'd1);
    load_pair(REGP_BC, 16'h00FF);
    bus_if.op_go  = 1'b1;
    bus_if.op_cmd = OP_INX;
    bus_if.op_rp  = 2'(REGP_BC);
    tick();
    bus_if.op_go = 1'b0;
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    m_cy = 1'b0;
    check("rst_bsy", {31'h0, bus_if.op_bsy}, 32'd0);
    check_output("rst_pair");
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus_if.op_done) cnt++;
      tick();
    end
    check("rst_no_done", cnt, 0);

    // Randomized writes and operations against the pair model.
    do_reset();
    for (int k = 0; k < 80; k++) begin
      logic [1:0] cmd;
      int rp;
      if ($urandom_range(0, 2) == 0) begin
        apply_stimulus($urandom_range(0, 7), 8'($urandom));
      end else begin
        cmd = 2'($urandom_range(0, 3));
        rp  = $urandom_range(0, 3);
        run_op(cmd, rp, vld);
        check("rand_vld", {31'h0, vld}, {31'h0, (cmd == OP_DAD)});
        check_output("rand_pair");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
